alu_regfile_pipe: RTL



---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu_exec.sv | 117 +++++++++++
 rtl/alu_regfile_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared decode constants for alu_regfile_pipe / alu_exec.
//   - MIPS opcode and funct encodings of the supported integer subset
//   - out_flags bit positions
//   - instruction field slice positions
//   - reg_oob(): register-field range check against the RF depth
package alu_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // out_flags bit indices
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  // Field LSB positions
  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;

  // 1 when a 5-bit register field names an entry the RF does not have
  function automatic logic reg_oob(input logic [4:0] a, input int nregs);
    return int'({27'b0, a}) >= nregs;
  endfunction

endpackage

// File: rtl/alu_exec.sv
// alu_exec: combinational decode + execute of one MIPS integer instruction.
// Ports:
//   instr    in  32      instruction word
//   rs_val   in  XLEN    value of register rs
//   rt_val   in  XLEN    value of register rt
//   result   out XLEN    ALU result (0 when illegal)
//   flags    out 3       [2] zero, [1] negative, [0] overflow
//   illegal  out 1       unknown encoding or register field >= NREGS
//   wb_en    out 1       result must be written to the RF
//   wb_addr  out ADDR_W  destination register
module alu_exec
  import alu_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 4,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   rs_val,
  input  logic [XLEN-1:0]   rt_val,
  output logic [XLEN-1:0]   result,
  output logic [2:0]        flags,
  output logic              illegal,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr
);
  localparam int SHW = $clog2(XLEN);
  localparam int M   = XLEN - 1;

  logic [5:0]      op, fn;
  logic [4:0]      rs, rt, rd;
  logic [SHW-1:0]  sh_imm, sh_var;
  logic [XLEN-1:0] imm_s, imm_z, sum, diff, isum;
  logic            add_ovf, sub_ovf, addi_ovf;
  logic            slt_s, slt_u, slti_s, slti_u, bad_reg;

  assign op = instr[OP_LSB +: 6];
  assign fn = instr[FN_LSB +: 6];
  assign rs = instr[RS_LSB +: 5];
  assign rt = instr[RT_LSB +: 5];
  assign rd = instr[RD_LSB +: 5];

  // Size casts both mask (narrow XLEN) and extend (XLEN=64) the shift count
  assign sh_imm = SHW'(instr[SH_LSB +: 5]);
  assign sh_var = rs_val[SHW-1:0];

  assign imm_s = XLEN'($signed(instr[IMM_LSB +: 16]));
  assign imm_z = XLEN'(instr[IMM_LSB +: 16]);

  assign sum  = rs_val + rt_val;
  assign diff = rs_val - rt_val;
  assign isum = rs_val + imm_s;

  assign add_ovf  = (rs_val[M] == rt_val[M]) && (sum[M]  != rs_val[M]);
  assign sub_ovf  = (rs_val[M] != rt_val[M]) && (diff[M] != rs_val[M]);
  assign addi_ovf = (rs_val[M] == imm_s[M])  && (isum[M] != rs_val[M]);

  assign slt_s  = $signed(rs_val) < $signed(rt_val);
  assign slt_u  = rs_val < rt_val;
  assign slti_s = $signed(rs_val) < $signed(imm_s);
  assign slti_u = rs_val < imm_s;

  always_comb begin
    result  = '0;
    flags   = '0;
    illegal = 1'b0;
    wb_en   = 1'b0;
    wb_addr = ADDR_W'(rt);
    bad_reg = reg_oob(rs, NREGS) || reg_oob(rt, NREGS);
    case (op)
      OP_RTYPE: begin
        wb_en   = 1'b1;
        wb_addr = ADDR_W'(rd);
        bad_reg = reg_oob(rs, NREGS) || reg_oob(rt, NREGS) || reg_oob(rd, NREGS);
        case (fn)
          // immediate shifts never touch rs, so its field is not range-checked
          FN_SLL:  begin result = rt_val << sh_imm; bad_reg = reg_oob(rt, NREGS) || reg_oob(rd, NREGS); end
          FN_SRL:  begin result = rt_val >> sh_imm; bad_reg = reg_oob(rt, NREGS) || reg_oob(rd, NREGS); end
          FN_SRA:  begin result = $unsigned($signed(rt_val) >>> sh_imm); bad_reg = reg_oob(rt, NREGS) || reg_oob(rd, NREGS); end
          FN_SLLV: result = rt_val << sh_var;
          FN_SRLV: result = rt_val >> sh_var;
          FN_SRAV: result = $unsigned($signed(rt_val) >>> sh_var);
          FN_ADD:  begin result = sum;  flags[FLAG_OVF] = add_ovf; end
          FN_ADDU: result = sum;
          FN_SUB:  begin result = diff; flags[FLAG_OVF] = sub_ovf; end
          FN_SUBU: result = diff;
          FN_AND:  result = rs_val & rt_val;
          FN_OR:   result = rs_val | rt_val;
          FN_XOR:  result = rs_val ^ rt_val;
          FN_NOR:  result = ~(rs_val | rt_val);
          FN_SLT:  begin result = {{(XLEN-1){1'b0}}, slt_s}; flags[FLAG_NEG] = slt_s; end
          FN_SLTU: begin result = {{(XLEN-1){1'b0}}, slt_u}; flags[FLAG_NEG] = slt_u; end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI:  begin result = isum; flags[FLAG_OVF] = addi_ovf; wb_en = 1'b1; end
      OP_ADDIU: begin result = isum; wb_en = 1'b1; end
      OP_SLTI:  begin result = {{(XLEN-1){1'b0}}, slti_s}; flags[FLAG_NEG] = slti_s; wb_en = 1'b1; end
      OP_SLTIU: begin result = {{(XLEN-1){1'b0}}, slti_u}; flags[FLAG_NEG] = slti_u; wb_en = 1'b1; end
      OP_ANDI:  begin result = rs_val & imm_z; wb_en = 1'b1; end
      OP_ORI:   begin result = rs_val | imm_z; wb_en = 1'b1; end
      OP_XORI:  begin result = rs_val ^ imm_z; wb_en = 1'b1; end
      OP_BEQ:   begin result = diff; flags[FLAG_ZERO] = (rs_val == rt_val); end
      OP_BNE:   begin result = diff; flags[FLAG_ZERO] = (rs_val != rt_val); end
      OP_LW,
      OP_SW:    result = isum;
      default:  illegal = 1'b1;
    endcase
    if (illegal || bad_reg) begin
      result  = '0;
      flags   = '0;
      wb_en   = 1'b0;
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: 2-stage MIPS ALU with an NREGS-entry register file.
//   S1 holds the accepted instruction; alu_exec runs combinationally on S1 and
//   the RF; S2 registers the outcome. Writeback happens on the S1->S2 edge, so
//   the next instruction in S1 already sees it (no forwarding).
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready/in_instr   instruction handshake
//   rf_wr_en/_addr/_data         external RF preload (pipeline write wins)
//   out_valid/out_ready          result handshake
//   out_result/out_flags/out_illegal/out_wb  registered outcome
// Optional (macro ALU_STATS_EN): stat_retired, stat_ovf saturating counters
//   of output handshakes and of handshakes with the overflow flag set.
module alu_regfile_pipe
  import alu_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 4,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              rf_wr_en,
  input  logic [ADDR_W-1:0] rf_wr_addr,
  input  logic [XLEN-1:0]   rf_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [2:0]        out_flags,
  output logic              out_illegal,
  output logic              out_wb
`ifdef ALU_STATS_EN
  ,
  output logic [31:0]       stat_retired,
  output logic [31:0]       stat_ovf
`endif
);

  // vld_pipe[0] = S1 occupied, vld_pipe[1] = S2 occupied (== out_valid)
  logic [1:0]                  vld_pipe;
  logic [31:0]                 s1_instr;
  logic [NREGS-1:0][XLEN-1:0]  rf;
  logic                        s2_load, s1_adv;
  logic [ADDR_W-1:0]           rs_idx, rt_idx, ex_wb_addr;
  logic [XLEN-1:0]             ex_result;
  logic [2:0]                  ex_flags;
  logic                        ex_illegal, ex_wb_en;

  assign out_valid = vld_pipe[1];
  assign s2_load   = !vld_pipe[1] || out_ready;
  assign s1_adv    = vld_pipe[0] && s2_load;
  assign in_ready  = !vld_pipe[0] || s1_adv;

  // Out-of-range fields alias here but alu_exec flags them illegal anyway
  assign rs_idx = ADDR_W'(s1_instr[RS_LSB +: 5]);
  assign rt_idx = ADDR_W'(s1_instr[RT_LSB +: 5]);

  alu_exec #(.XLEN(XLEN), .NREGS(NREGS)) u_exec (
    .instr   (s1_instr),
    .rs_val  (rf[rs_idx]),
    .rt_val  (rf[rt_idx]),
    .result  (ex_result),
    .flags   (ex_flags),
    .illegal (ex_illegal),
    .wb_en   (ex_wb_en),
    .wb_addr (ex_wb_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      s1_instr    <= '0;
      out_result  <= '0;
      out_flags   <= '0;
      out_illegal <= 1'b0;
      out_wb      <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        vld_pipe[0] <= 1'b1;
        s1_instr    <= in_instr;
      end else if (s1_adv) begin
        vld_pipe[0] <= 1'b0;
      end
      if (s2_load) vld_pipe[1] <= vld_pipe[0];
      if (s1_adv) begin
        out_result  <= ex_result;
        out_flags   <= ex_flags;
        out_illegal <= ex_illegal;
        out_wb      <= ex_wb_en;
      end
    end
  end

  // Pipeline write is issued last so it overrides a same-address preload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= '0;
    end else begin
      if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
      if (s1_adv && ex_wb_en) rf[ex_wb_addr] <= ex_result;
    end
  end

`ifdef ALU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_retired <= '0;
      stat_ovf     <= '0;
    end else if (out_valid && out_ready) begin
      if (stat_retired != '1) stat_retired <= stat_retired + 32'd1;
      if (out_flags[FLAG_OVF] && stat_ovf != '1) stat_ovf <= stat_ovf + 32'd1;
    end
  end
`endif

endmodule
